ulpb_sleep_ctrl: RTL



---
 rtl/ulpb_sleep_ctrl_if.sv | 24 ++
 rtl/ulpb_sleep_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ulpb_sleep_ctrl_if.sv
// Handshake bundle between a ULPB layer's sleep controller and its node / bus-controller domain.
// master: node/bus side that drives the wake and sleep inputs; slave: the always-on sleep controller.
interface ulpb_sleep_ctrl_if;
   logic DIN;
   logic SLEEP_REQUEST;
   logic EXTERNAL_INT;
   logic POWER_ON_TO_BUS_CTRL;
   logic RELEASE_CLK_TO_BUS_CTRL;
   logic RELEASE_ISO_TO_BUS_CTRL;
   logic RELEASE_RST_TO_BUS_CTRL;
   logic BUS_AWAKE;

   modport master (
      output DIN, SLEEP_REQUEST, EXTERNAL_INT,
      input  POWER_ON_TO_BUS_CTRL, RELEASE_CLK_TO_BUS_CTRL,
      input  RELEASE_ISO_TO_BUS_CTRL, RELEASE_RST_TO_BUS_CTRL, BUS_AWAKE
   );

   modport slave (
      input  DIN, SLEEP_REQUEST, EXTERNAL_INT,
      output POWER_ON_TO_BUS_CTRL, RELEASE_CLK_TO_BUS_CTRL,
      output RELEASE_ISO_TO_BUS_CTRL, RELEASE_RST_TO_BUS_CTRL, BUS_AWAKE
   );
endinterface

// File: rtl/ulpb_sleep_ctrl.sv
// Always-on sleep controller: sequences power/clock/isolation/reset of the bus-controller domain.
// Define ULPB_SLEEP_EXT_INT_WAKE_EN to let EXTERNAL_INT wake the layer in addition to DIN low.
module ulpb_sleep_ctrl #(
   parameter int POWER_SETTLE = 4
) (
   input logic               CLK_EXT,
   input logic               RESETn,
   ulpb_sleep_ctrl_if.slave  bus
);

   // Gating encoding shared with the bus controller (IO_HOLD / IO_RELEASE).
   localparam logic IO_HOLD    = 1'b1;
   localparam logic IO_RELEASE = 1'b0;

   localparam logic [7:0] SETTLE_LAST = 8'(POWER_SETTLE - 1);

   localparam int SYN_DIN = 0;
   localparam int SYN_REQ = 1;
`ifdef ULPB_SLEEP_EXT_INT_WAKE_EN
   localparam int SYN_EXT = 2;
   localparam int NSYNC   = 3;
`else
   localparam int NSYNC   = 2;
`endif
   // Bus idles high, so the DIN synchronizer resets to 1 and the rest to 0.
   localparam logic [NSYNC-1:0] SYNC_IDLE = NSYNC'(1);

   typedef enum logic [2:0] {
      SLEEP, WK_SETTLE, WK_ISO, WK_RST, AWAKE, SL_ISO, SL_CLK, SL_PWR
   } state_t;

   logic [NSYNC-1:0] sync_raw;
   logic [NSYNC-1:0] sync_s2;
   logic             sleep_prev_reg;
   logic             wake;
   logic             sleep_rise;

   state_t     state_reg,     state_next;
   logic [7:0] cnt_reg,       cnt_next;
   logic       wake_pend_reg, wake_pend_next;
   logic       power_reg,     power_next;
   logic       clk_rel_reg,   clk_rel_next;
   logic       iso_reg,       iso_next;
   logic       rst_reg,       rst_next;

   assign sync_raw[SYN_DIN] = bus.DIN;
   assign sync_raw[SYN_REQ] = bus.SLEEP_REQUEST;
`ifdef ULPB_SLEEP_EXT_INT_WAKE_EN
   assign sync_raw[SYN_EXT] = bus.EXTERNAL_INT;
`endif

   generate
      for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
         logic s1_reg;
         logic s2_reg;
         always_ff @(posedge CLK_EXT or negedge RESETn) begin
            if (!RESETn) begin
               s1_reg <= SYNC_IDLE[gi];
               s2_reg <= SYNC_IDLE[gi];
            end else begin
               s1_reg <= sync_raw[gi];
               s2_reg <= s1_reg;
            end
         end
         assign sync_s2[gi] = s2_reg;
      end
   endgenerate

   always_ff @(posedge CLK_EXT or negedge RESETn) begin
      if (!RESETn) sleep_prev_reg <= 1'b0;
      else         sleep_prev_reg <= sync_s2[SYN_REQ];
   end

   assign sleep_rise = sync_s2[SYN_REQ] & ~sleep_prev_reg;
`ifdef ULPB_SLEEP_EXT_INT_WAKE_EN
   assign wake = ~sync_s2[SYN_DIN] | sync_s2[SYN_EXT];
`else
   assign wake = ~sync_s2[SYN_DIN];
`endif

   always_ff @(posedge CLK_EXT or negedge RESETn) begin
      if (!RESETn) begin
         state_reg     <= SLEEP;
         cnt_reg       <= 8'd0;
         wake_pend_reg <= 1'b0;
         power_reg     <= IO_HOLD;
         clk_rel_reg   <= IO_HOLD;
         iso_reg       <= IO_HOLD;
         rst_reg       <= IO_HOLD;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         wake_pend_reg <= wake_pend_next;
         power_reg     <= power_next;
         clk_rel_reg   <= clk_rel_next;
         iso_reg       <= iso_next;
         rst_reg       <= rst_next;
      end
   end

   // Each state touches at most one gating output, which keeps the up/down ordering glitch-free.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      wake_pend_next = wake_pend_reg;
      power_next     = power_reg;
      clk_rel_next   = clk_rel_reg;
      iso_next       = iso_reg;
      rst_next       = rst_reg;
      case (state_reg)
         SLEEP: begin
            if (wake || wake_pend_reg) begin
               power_next     = IO_RELEASE;
               cnt_next       = 8'd0;
               wake_pend_next = 1'b0;
               state_next     = WK_SETTLE;
            end
         end
         WK_SETTLE: begin
            if (cnt_reg == SETTLE_LAST) begin
               clk_rel_next = IO_RELEASE;
               state_next   = WK_ISO;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         WK_ISO: begin
            iso_next   = IO_RELEASE;
            state_next = WK_RST;
         end
         WK_RST: begin
            rst_next   = IO_RELEASE;
            state_next = AWAKE;
         end
         AWAKE: begin
            if (sleep_rise) begin
               rst_next   = IO_HOLD;
               state_next = SL_ISO;
            end
         end
         // A wake seen while going down is remembered and served once SLEEP is reached.
         SL_ISO: begin
            iso_next       = IO_HOLD;
            wake_pend_next = wake_pend_reg | wake;
            state_next     = SL_CLK;
         end
         SL_CLK: begin
            clk_rel_next   = IO_HOLD;
            wake_pend_next = wake_pend_reg | wake;
            state_next     = SL_PWR;
         end
         SL_PWR: begin
            power_next     = IO_HOLD;
            wake_pend_next = wake_pend_reg | wake;
            state_next     = SLEEP;
         end
         default: state_next = SLEEP;
      endcase
   end

   assign bus.POWER_ON_TO_BUS_CTRL    = power_reg;
   assign bus.RELEASE_CLK_TO_BUS_CTRL = clk_rel_reg;
   assign bus.RELEASE_ISO_TO_BUS_CTRL = iso_reg;
   assign bus.RELEASE_RST_TO_BUS_CTRL = rst_reg;
   assign bus.BUS_AWAKE               = (state_reg == AWAKE);

endmodule
